// File: rtl/image_tx_scheduler.sv
// Frame transmit sequencer: freezes the frame buffer, then streams a sync header,
// every pixel as two bytes and a trailing mod-256 checksum to the UART.
module image_tx_scheduler #(
  parameter int         NUM_PIXELS = 76800,
  parameter int         ADDR_W     = 17,
  parameter logic [7:0] SYNC0      = 8'hA5,
  parameter logic [7:0] SYNC1      = 8'h5A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              capture_busy,
  output logic              freeze,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [11:0]       pixel,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    WAIT_CAP = 4'd1,
    HDR0     = 4'd2,
    HDR1     = 4'd3,
    FETCH    = 4'd4,
    LATCH    = 4'd5,
    PIX_HI   = 4'd6,
    PIX_LO   = 4'd7,
    CKSUM    = 4'd8,
    DONE     = 4'd9
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  function automatic logic [7:0] cksum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

  state_t      state, next_state;
  logic [11:0] pix_reg, pix_next;
  logic [7:0]  cksum, cksum_next;
  logic [7:0]  tx_data_d;
  logic        tx_valid_d, busy_d, done_d;
  logic        hs, last_pix, leaving_idle;

  assign hs           = tx_valid & tx_ready;
  assign last_pix     = (rd_addr == LAST_ADDR);
  assign leaving_idle = (state == IDLE) && start;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (start) next_state = WAIT_CAP; else next_state = IDLE;
      WAIT_CAP: if (!capture_busy) next_state = HDR0; else next_state = WAIT_CAP;
      HDR0:     if (hs) next_state = HDR1; else next_state = HDR0;
      HDR1:     if (hs) next_state = FETCH; else next_state = HDR1;
      FETCH:    next_state = LATCH;
      LATCH:    next_state = PIX_HI;
      PIX_HI:   if (hs) next_state = PIX_LO; else next_state = PIX_HI;
      PIX_LO: begin
        if (hs) next_state = last_pix ? CKSUM : FETCH;
        else    next_state = PIX_LO;
      end
      CKSUM:    if (hs) next_state = DONE; else next_state = CKSUM;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Output logic: outputs are registered, so decode from next_state and the
  // values pix_reg/cksum will hold after this edge
  always_comb begin
    pix_next = (state == LATCH) ? pixel : pix_reg;
    if (leaving_idle)
      cksum_next = 8'h00;
    else if (hs && ((state == PIX_HI) || (state == PIX_LO)))
      cksum_next = cksum_add(cksum, tx_data);
    else
      cksum_next = cksum;
    tx_valid_d = 1'b0;
    tx_data_d  = 8'h00;
    case (next_state)
      HDR0:    begin tx_valid_d = 1'b1; tx_data_d = SYNC0; end
      HDR1:    begin tx_valid_d = 1'b1; tx_data_d = SYNC1; end
      PIX_HI:  begin tx_valid_d = 1'b1; tx_data_d = {4'h0, pix_next[11:8]}; end
      PIX_LO:  begin tx_valid_d = 1'b1; tx_data_d = pix_next[7:0]; end
      CKSUM:   begin tx_valid_d = 1'b1; tx_data_d = cksum_next; end
      default: begin tx_valid_d = 1'b0; tx_data_d = 8'h00; end
    endcase
    busy_d = (next_state != IDLE);
    done_d = (next_state == DONE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr  <= '0;
      pix_reg  <= 12'h000;
      cksum    <= 8'h00;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      freeze   <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (leaving_idle)
        rd_addr <= '0;
      else if ((state == PIX_LO) && hs && !last_pix)
        rd_addr <= rd_addr + ADDR_W'(1);
      else
        rd_addr <= rd_addr;
      pix_reg  <= pix_next;
      cksum    <= cksum_next;
      tx_data  <= tx_data_d;
      tx_valid <= tx_valid_d;
      busy     <= busy_d;
      freeze   <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_image_tx_scheduler.sv
// Scoreboard bench for image_tx_scheduler: a 4-pixel instance and a 1-pixel instance.
module tb_image_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tx_ready = 1'b1;
  logic        capture_busy = 1'b0;
  logic        start4 = 1'b0, start1 = 1'b0;
  logic        freeze4, freeze1, tx_valid4, tx_valid1, busy4, busy1, done4, done1;
  logic [16:0] rd_addr4, rd_addr1;
  logic [7:0]  tx_data4, tx_data1;
  logic [11:0] pixel4 = 12'h000, pixel1 = 12'h000;
  logic [11:0] mem4 [4] = '{12'hABC, 12'h123, 12'h000, 12'hFFF};

  int n_checks = 0, n_errors = 0;
  int cyc = 0, bytes4 = 0, hs_cyc4 = 0, hs_cyc1 = 0;
  logic rand_mode = 1'b0;
  logic hold4 = 1'b0, rd1_moved = 1'b0;
  logic [7:0] hold_data4 = 8'h00;
  logic [7:0] exp4[$], exp1[$];
  logic [7:0] frame4 [11] = '{8'hA5, 8'h5A, 8'h0A, 8'hBC, 8'h01, 8'h23, 8'h00, 8'h00, 8'h0F, 8'hFF, 8'hF8};
  logic [7:0] frame1 [5]  = '{8'hA5, 8'h5A, 8'h07, 8'hE5, 8'hEC};

  image_tx_scheduler #(.NUM_PIXELS(4), .ADDR_W(17)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .capture_busy(capture_busy), .freeze(freeze4),
    .rd_addr(rd_addr4), .pixel(pixel4), .tx_data(tx_data4), .tx_valid(tx_valid4),
    .tx_ready(tx_ready), .busy(busy4), .done(done4));

  image_tx_scheduler #(.NUM_PIXELS(1), .ADDR_W(17)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .capture_busy(capture_busy), .freeze(freeze1),
    .rd_addr(rd_addr1), .pixel(pixel1), .tx_data(tx_data1), .tx_valid(tx_valid1),
    .tx_ready(tx_ready), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous RAM models: data valid one cycle after the address changes
  always @(posedge clk) begin
    cyc++;
    pixel4 <= (rd_addr4 < 17'd4) ? mem4[rd_addr4[1:0]] : 12'hxxx;
    pixel1 <= (rd_addr1 == 17'd0) ? 12'h7E5 : 12'hxxx;
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1 tx_ready = 1'($urandom_range(0, 1));
    end
  end

  // Byte monitor: pop the scoreboard on each handshake, check stall stability
  always @(negedge clk) begin
    if (!rst) begin
      if (hold4) begin
        check("hold_valid", {31'd0, tx_valid4}, 32'd1);
        check("hold_data", {24'd0, tx_data4}, {24'd0, hold_data4});
      end
      hold4 = tx_valid4 && !tx_ready;
      hold_data4 = tx_data4;
      if (tx_valid4 && tx_ready) begin
        bytes4++;
        hs_cyc4 = cyc;
        if (exp4.size() == 0) check("extra_byte4", {24'd0, tx_data4}, 32'hFFFF_FFFF);
        else check("byte4", {24'd0, tx_data4}, {24'd0, exp4.pop_front()});
      end
      if (tx_valid1 && tx_ready) begin
        hs_cyc1 = cyc;
        if (exp1.size() == 0) check("extra_byte1", {24'd0, tx_data1}, 32'hFFFF_FFFF);
        else check("byte1", {24'd0, tx_data1}, {24'd0, exp1.pop_front()});
      end
      if (rd_addr1 != 17'd0) rd1_moved = 1'b1;
    end else begin
      hold4 = 1'b0;
    end
  end

  task automatic push_frame4();
    for (int i = 0; i < 11; i++) exp4.push_back(frame4[i]);
  endtask

  task automatic pulse_start4();
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
  endtask

  task automatic wait_done4(input logic poke);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done4 !== 1'b1 && n < 3000);
    if (done4 !== 1'b1) begin
      check("done4_timeout", 32'd0, 32'd1);
      return;
    end
    check("done_latency", cyc - hs_cyc4, 32'd1);
    check("freeze_in_done", {31'd0, freeze4}, 32'd1);
    check("sb_empty", exp4.size(), 32'd0);
    if (poke) start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("done_pulse", {31'd0, done4}, 32'd0);
    check("freeze_after", {31'd0, freeze4}, 32'd0);
    check("busy_after", {31'd0, busy4}, 32'd0);
  endtask

  initial begin
    int b0;
    logic any_valid;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_valid", {31'd0, tx_valid4}, 32'd0);
    check("rst_freeze", {31'd0, freeze4}, 32'd0);
    check("rst_busy", {31'd0, busy4}, 32'd0);
    check("rst_done", {31'd0, done4}, 32'd0);
    check("rst_rd_addr", {15'd0, rd_addr4}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data4}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Full-rate frame
    push_frame4();
    pulse_start4();
    check("freeze_start", {31'd0, freeze4}, 32'd1);
    wait_done4(1'b0);
    check("rd_addr_hold", {15'd0, rd_addr4}, 32'd3);

    // Random back-pressure
    push_frame4();
    rand_mode = 1'b1;
    pulse_start4();
    wait_done4(1'b0);
    rand_mode = 1'b0;
    @(posedge clk); #1 tx_ready = 1'b1;

    // Capture in progress for 20 cycles
    capture_busy = 1'b1;
    push_frame4();
    pulse_start4();
    check("freeze_cap", {31'd0, freeze4}, 32'd1);
    any_valid = tx_valid4;
    repeat (19) begin
      @(posedge clk); #1 any_valid |= tx_valid4;
    end
    capture_busy = 1'b0;
    check("no_valid_cap", {31'd0, any_valid | tx_valid4}, 32'd0);
    @(posedge clk); #1;
    check("valid_after_cap", {31'd0, tx_valid4}, 32'd1);
    check("hdr_after_cap", {24'd0, tx_data4}, 32'hA5);
    wait_done4(1'b0);

    // Restart attempts mid-stream and in DONE
    b0 = bytes4;
    push_frame4();
    pulse_start4();
    repeat (10) @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    check("busy_mid", {31'd0, busy4}, 32'd1);
    wait_done4(1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("busy_idle", {31'd0, busy4}, 32'd0);
    check("frame_bytes", bytes4 - b0, 32'd11);

    // Reset during 3rd pixel's PIX_LO
    b0 = bytes4;
    push_frame4();
    pulse_start4();
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (bytes4 - b0 != 7 && n < 200);
    @(posedge clk); #1;
    check("pre_rst_lo", {23'd0, tx_valid4, tx_data4}, 32'h100);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_valid", {31'd0, tx_valid4}, 32'd0);
    check("midrst_freeze", {31'd0, freeze4}, 32'd0);
    check("midrst_busy", {31'd0, busy4}, 32'd0);
    exp4.delete();
    rst = 1'b0;
    push_frame4();
    pulse_start4();
    wait_done4(1'b0);

    // Single-pixel frame
    for (int i = 0; i < 5; i++) exp1.push_back(frame1[i]);
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done1 !== 1'b1 && n < 200);
    check("done1", {31'd0, done1}, 32'd1);
    check("done1_latency", cyc - hs_cyc1, 32'd1);
    check("sb1_empty", exp1.size(), 32'd0);
    check("rd1_fixed", {31'd0, rd1_moved}, 32'd0);
    @(negedge clk);
    check("busy1_after", {31'd0, busy1}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
